// File: rtl/roi_downsampler_if.sv
// Camera-side input and conv-side output signals of the ROI downsampler.
// The slave modport is used by the downsampler and the master modport by whatever drives it.
interface roi_downsampler_if;
  logic       en;
  logic       cam_href;
  logic       cam_vsync;
  logic [7:0] cam_data;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       frame_start;
  logic       frame_done;
  logic       frame_err;

  modport master (
    output en, cam_href, cam_vsync, cam_data,
    input  pix_valid, pix_data, frame_start, frame_done, frame_err
  );

  modport slave (
    input  en, cam_href, cam_vsync, cam_data,
    output pix_valid, pix_data, frame_start, frame_done, frame_err
  );
endinterface

// File: rtl/roi_downsampler.sv
// Crops a square region of interest from the camera stream and box-averages it
// into an OUT_SIZE x OUT_SIZE row-major pixel stream for the convolution stage.
module roi_downsampler #(
  parameter int SRC_WIDTH  = 640,
  parameter int SRC_HEIGHT = 480,
  parameter int ROI_X0     = 180,
  parameter int ROI_Y0     = 100,
  parameter int SCALE      = 10,
  parameter int OUT_SIZE   = 28,
  parameter int RECIP      = 656
) (
  input logic              clk,
  input logic              rst,
  roi_downsampler_if.slave bus
);

  localparam int XW   = $clog2(SRC_WIDTH + 1);
  localparam int YW   = $clog2(SRC_HEIGHT + 1);
  localparam int SXW  = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int BW   = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int NOUT = OUT_SIZE * OUT_SIZE;
  localparam int OW   = $clog2(NOUT + 1);
  localparam int RW   = $clog2(RECIP + 1);
  localparam int PW   = 16 + RW;

  localparam logic [XW-1:0]  X_MAX   = XW'(SRC_WIDTH);
  localparam logic [XW-1:0]  X_LO    = XW'(ROI_X0);
  localparam logic [XW-1:0]  X_HI    = XW'(ROI_X0 + OUT_SIZE * SCALE);
  localparam logic [YW-1:0]  Y_MAX   = YW'(SRC_HEIGHT);
  localparam logic [YW-1:0]  Y_LO    = YW'(ROI_Y0);
  localparam logic [YW-1:0]  Y_HI    = YW'(ROI_Y0 + OUT_SIZE * SCALE);
  localparam logic [SXW-1:0] S_LAST  = SXW'(SCALE - 1);
  localparam logic [BW-1:0]  B_LAST  = BW'(OUT_SIZE - 1);
  localparam logic [OW-1:0]  OC_END  = OW'(NOUT);
  localparam logic [RW-1:0]  RECIP_C = RW'(RECIP);

  localparam logic [1:0] WAIT_VS = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  logic [1:0]     state_r;
  logic           vsync_d_r;
  logic           href_d_r;
  logic [XW-1:0]  x_r;
  logic [YW-1:0]  y_r;
  logic [SXW-1:0] sx_r;
  logic [SXW-1:0] sy_r;
  logic [BW-1:0]  bx_r;
  logic [OW-1:0]  oc_r;
  logic           s1_valid_r;
  logic [15:0]    sum_r;
  logic           pix_valid_r;
  logic [7:0]     pix_data_r;
  logic           frame_start_r;
  logic           frame_done_r;
  logic           frame_err_r;
  logic [15:0]    acc_r [0:OUT_SIZE-1];

  logic           vsync_rise_s;
  logic           vsync_fall_s;
  logic           href_fall_s;
  logic           capture_s;
  logic           done_s;
  logic           abort_s;
  logic           y_in_roi_s;
  logic           in_roi_s;
  logic           blk_first_s;
  logic           blk_last_s;
  logic           emit_s;
  logic [15:0]    acc_sum_s;
  logic [15:0]    acc_next_s;
  logic [PW-1:0]  prod_s;
  logic [PW-1:0]  avg_full_s;
  logic [7:0]     avg_s;

  // Edge detection, frame control decisions and the averaging arithmetic.
  always_comb begin
    vsync_rise_s = bus.cam_vsync & ~vsync_d_r;
    vsync_fall_s = ~bus.cam_vsync & vsync_d_r;
    href_fall_s  = ~bus.cam_href & href_d_r;
    capture_s    = (state_r == CAPTURE);
    // the final output is visible this cycle; a simultaneous vsync edge is not an abort
    done_s       = capture_s & pix_valid_r & (oc_r == OC_END);
    abort_s      = capture_s & vsync_rise_s & ~done_s;
    y_in_roi_s   = (y_r >= Y_LO) && (y_r < Y_HI);
    in_roi_s     = capture_s & ~abort_s & bus.cam_href & y_in_roi_s &
                   (x_r >= X_LO) & (x_r < X_HI);
    blk_first_s  = (sx_r == {SXW{1'b0}}) && (sy_r == {SXW{1'b0}});
    blk_last_s   = (sx_r == S_LAST) && (sy_r == S_LAST);
    emit_s       = s1_valid_r & capture_s & ~abort_s;
    acc_sum_s    = acc_r[bx_r] + {8'd0, bus.cam_data};
    if (blk_first_s) begin
      acc_next_s = {8'd0, bus.cam_data};
    end else begin
      acc_next_s = acc_sum_s;
    end
    prod_s     = PW'(sum_r) * PW'(RECIP_C);
    avg_full_s = prod_s >> 16;
    if (avg_full_s > PW'(255)) begin
      avg_s = 8'hFF;
    end else begin
      avg_s = avg_full_s[7:0];
    end
  end

  // Frame state machine, input edge history and the status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= WAIT_VS;
      vsync_d_r    <= 1'b0;
      href_d_r     <= 1'b0;
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      vsync_d_r    <= bus.cam_vsync;
      href_d_r     <= bus.cam_href;
      frame_done_r <= done_s;
      frame_err_r  <= abort_s;
      case (state_r)
        WAIT_VS: state_r <= (vsync_rise_s && bus.en) ? ARMED : WAIT_VS;
        ARMED:   state_r <= vsync_fall_s ? CAPTURE : ARMED;
        CAPTURE: begin
          if (done_s) begin
            state_r <= (vsync_rise_s && bus.en) ? ARMED : WAIT_VS;
          end else if (abort_s) begin
            state_r <= bus.en ? ARMED : WAIT_VS;
          end else begin
            state_r <= CAPTURE;
          end
        end
        default: state_r <= WAIT_VS;
      endcase
    end
  end

  // Source position and block sub-position counters, cleared while armed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r  <= {XW{1'b0}};
      y_r  <= {YW{1'b0}};
      sx_r <= {SXW{1'b0}};
      sy_r <= {SXW{1'b0}};
      bx_r <= {BW{1'b0}};
    end else if (state_r == ARMED) begin
      x_r  <= {XW{1'b0}};
      y_r  <= {YW{1'b0}};
      sx_r <= {SXW{1'b0}};
      sy_r <= {SXW{1'b0}};
      bx_r <= {BW{1'b0}};
    end else if (capture_s) begin
      if (bus.cam_href) begin
        if (x_r != X_MAX) begin
          x_r <= x_r + XW'(1);
        end
      end else if (href_fall_s) begin
        x_r  <= {XW{1'b0}};
        sx_r <= {SXW{1'b0}};
        bx_r <= {BW{1'b0}};
        if (y_r != Y_MAX) begin
          y_r <= y_r + YW'(1);
        end
        if (y_in_roi_s) begin
          sy_r <= (sy_r == S_LAST) ? {SXW{1'b0}} : sy_r + SXW'(1);
        end
      end
      if (in_roi_s) begin
        if (sx_r == S_LAST) begin
          sx_r <= {SXW{1'b0}};
          bx_r <= (bx_r == B_LAST) ? {BW{1'b0}} : bx_r + BW'(1);
        end else begin
          sx_r <= sx_r + SXW'(1);
        end
      end
    end
  end

  // Per-column block accumulators; every block restarts on its first pixel.
  always_ff @(posedge clk) begin
    if (in_roi_s) begin
      acc_r[bx_r] <= acc_next_s;
    end
  end

  // Two-stage emit pipeline: latch the block sum, then scale and saturate it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r    <= 1'b0;
      sum_r         <= 16'd0;
      pix_valid_r   <= 1'b0;
      pix_data_r    <= 8'd0;
      frame_start_r <= 1'b0;
      oc_r          <= {OW{1'b0}};
    end else begin
      s1_valid_r    <= in_roi_s & blk_last_s;
      pix_valid_r   <= emit_s;
      frame_start_r <= emit_s & (oc_r == {OW{1'b0}});
      if (in_roi_s && blk_last_s) begin
        sum_r <= acc_sum_s;
      end
      if (emit_s) begin
        pix_data_r <= avg_s;
        oc_r       <= oc_r + OW'(1);
      end else if (state_r == ARMED) begin
        oc_r <= {OW{1'b0}};
      end
    end
  end

  assign bus.pix_valid   = pix_valid_r;
  assign bus.pix_data    = pix_data_r;
  assign bus.frame_start = frame_start_r;
  assign bus.frame_done  = frame_done_r;
  assign bus.frame_err   = frame_err_r;

endmodule

// File: tb/tb_roi_downsampler.sv
// Randomised frame-level bench for roi_downsampler on a scaled-down geometry,
// checked against a block-average reference computed from the driven image.
module tb_roi_downsampler;
  localparam int SW = 40, SH = 30, RX = 7, RY = 5, SC = 3, OS = 6, RC = 7282;
  localparam int HB = 6, VB = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  roi_downsampler_if bus ();
  roi_downsampler #(
    .SRC_WIDTH(SW), .SRC_HEIGHT(SH), .ROI_X0(RX), .ROI_Y0(RY),
    .SCALE(SC), .OUT_SIZE(OS), .RECIP(RC)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] img [0:SH+3][0:SW+3];
  int comp_cyc [0:OS-1][0:OS-1];
  int o_cyc[$], fs_cyc[$], fd_cyc[$], fe_cyc[$], e_cyc[$];
  logic [7:0] o_dat[$], e_dat[$];
  int both_cnt;
  int rise_cyc, rst_cyc;
  logic pre_pv, post_pv;
  logic [7:0] pre_pd, post_pd;
  logic [2:0] post_pulses;

  // Output monitor, sampled 2 time units after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (bus.pix_valid === 1'b1) begin
      o_cyc.push_back(cyc);
      o_dat.push_back(bus.pix_data);
    end
    if (bus.frame_start === 1'b1) fs_cyc.push_back(cyc);
    if (bus.frame_done === 1'b1) fd_cyc.push_back(cyc);
    if (bus.frame_err === 1'b1) fe_cyc.push_back(cyc);
    if (bus.frame_done === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
  end

  task automatic clear_mon();
    o_cyc.delete(); o_dat.delete(); fs_cyc.delete(); fd_cyc.delete(); fe_cyc.delete();
    both_cnt = 0;
    for (int j = 0; j < OS; j++)
      for (int i = 0; i < OS; i++) comp_cyc[j][i] = -1;
  endtask

  // 0 constant, 1 horizontal ramp, 2 ROI-aligned checkerboard, 3 white, other random
  task automatic fill_image(input int p);
    for (int y = 0; y < SH + 4; y++)
      for (int x = 0; x < SW + 4; x++)
        case (p)
          0: img[y][x] = 8'h80;
          1: img[y][x] = x[7:0];
          2: img[y][x] = ((((x + 30 - RX) / SC) + ((y + 30 - RY) / SC)) % 2 == 1) ? 8'hFF : 8'h00;
          3: img[y][x] = 8'hFF;
          default: img[y][x] = 8'($urandom_range(0, 255));
        endcase
  endtask

  // Reference: each fully driven block is the scaled mean of its source pixels,
  // due 2 cycles after its bottom-right pixel was presented.
  task automatic build_exp();
    int sum, q;
    e_cyc.delete(); e_dat.delete();
    for (int by = 0; by < OS; by++)
      for (int bx = 0; bx < OS; bx++)
        if (comp_cyc[by][bx] >= 0) begin
          sum = 0;
          for (int j = 0; j < SC; j++)
            for (int i = 0; i < SC; i++) sum += int'(img[RY + by * SC + j][RX + bx * SC + i]);
          q = (sum * RC) >>> 16;
          if (q > 255) q = 255;
          e_cyc.push_back(comp_cyc[by][bx] + 2);
          e_dat.push_back(8'(q));
        end
  endtask

  task automatic vsync_start();
    @(negedge clk);
    bus.cam_vsync = 1'b1;
    rise_cyc = cyc;
    repeat (VB) @(negedge clk);
    bus.cam_vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_lines(input int y0, input int y1, input int llen, input int rst_y, input int rst_x);
    for (int y = y0; y < y1; y++) begin
      for (int x = 0; x < llen; x++) begin
        @(negedge clk);
        if (rst) rst = 1'b0;
        if (y == rst_y && x == rst_x) begin
          pre_pv = bus.pix_valid;
          pre_pd = bus.pix_data;
          rst = 1'b1;
          rst_cyc = cyc;
          #1;
          post_pv = bus.pix_valid;
          post_pd = bus.pix_data;
          post_pulses = {bus.frame_start, bus.frame_done, bus.frame_err};
        end
        bus.cam_href = 1'b1;
        bus.cam_data = img[y][x];
        if (x >= RX && x < RX + OS * SC && y >= RY && y < RY + OS * SC &&
            (x - RX) % SC == SC - 1 && (y - RY) % SC == SC - 1)
          comp_cyc[(y - RY) / SC][(x - RX) / SC] = cyc;
      end
      repeat (HB) begin
        @(negedge clk);
        if (rst) rst = 1'b0;
        bus.cam_href = 1'b0;
        bus.cam_data = 8'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.pix_valid, bus.pix_data, bus.frame_start, bus.frame_done, bus.frame_err} !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want all zero",
               {bus.pix_valid, bus.pix_data, bus.frame_start, bus.frame_done, bus.frame_err});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_patterns();
    int n, kexp;
    for (int p = 0; p < 5; p++) begin
      fill_image(p);
      clear_mon();
      vsync_start();
      if (p == 4) send_lines(0, SH + 3, SW + 4, -1, -1);
      else send_lines(0, SH, SW, -1, -1);
      build_exp();
      vectors++;
      if (o_dat.size() != OS * OS) begin
        miscompares++;
        $display("FAIL pat%0d out_count: got %0d want %0d", p, o_dat.size(), OS * OS);
      end
      n = (o_dat.size() < e_dat.size()) ? o_dat.size() : e_dat.size();
      for (int i = 0; i < n; i++) begin
        vectors++;
        if (o_dat[i] !== e_dat[i]) begin
          miscompares++;
          $display("FAIL pat%0d data[%0d]: got %h want %h", p, i, o_dat[i], e_dat[i]);
        end
        vectors++;
        if (o_cyc[i] != e_cyc[i]) begin
          miscompares++;
          $display("FAIL pat%0d latency[%0d]: got cycle %0d want %0d", p, i, o_cyc[i], e_cyc[i]);
        end
        kexp = -1;
        case (p)
          0: kexp = 8'h80;
          1: kexp = (i == 0) ? 8 : -1;
          2: kexp = (((i / OS) + (i % OS)) % 2 == 1) ? 8'hFF : 8'h00;
          3: kexp = 8'hFF;
          default: kexp = -1;
        endcase
        if (kexp >= 0) begin
          vectors++;
          if (int'(o_dat[i]) != kexp) begin
            miscompares++;
            $display("FAIL pat%0d known_value[%0d]: got %h want %h", p, i, o_dat[i], kexp);
          end
        end
      end
      vectors++;
      if (fs_cyc.size() != 1 || fs_cyc[0] != e_cyc[0]) begin
        miscompares++;
        $display("FAIL pat%0d frame_start: got %0d pulses", p, fs_cyc.size());
      end
      vectors++;
      if (fd_cyc.size() != 1 || fd_cyc[0] != e_cyc[e_cyc.size() - 1] + 1) begin
        miscompares++;
        $display("FAIL pat%0d frame_done: got %0d pulses", p, fd_cyc.size());
      end
      vectors++;
      if (fe_cyc.size() != 0 || both_cnt != 0) begin
        miscompares++;
        $display("FAIL pat%0d frame_err: got %0d pulses want 0", p, fe_cyc.size());
      end
    end
  endtask

  task automatic test_abort(input bit short_lines);
    int n;
    fill_image(4);
    clear_mon();
    vsync_start();
    if (short_lines) send_lines(0, SH, RX + 3 * SC + 1, -1, -1);
    else send_lines(0, RY + 2 * SC, SW, -1, -1);
    build_exp();
    vsync_start();
    vectors++;
    if (o_dat.size() != (short_lines ? OS * 3 : OS * 2)) begin
      miscompares++;
      $display("FAIL abort%0d out_count: got %0d want %0d", short_lines, o_dat.size(),
               short_lines ? OS * 3 : OS * 2);
    end
    n = (o_dat.size() < e_dat.size()) ? o_dat.size() : e_dat.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (o_dat[i] !== e_dat[i] || o_cyc[i] != e_cyc[i]) begin
        miscompares++;
        $display("FAIL abort%0d out[%0d]: got %h@%0d want %h@%0d", short_lines, i,
                 o_dat[i], o_cyc[i], e_dat[i], e_cyc[i]);
      end
    end
    vectors++;
    if (fe_cyc.size() != 1 || fe_cyc[0] != rise_cyc + 1) begin
      miscompares++;
      $display("FAIL abort%0d frame_err: got %0d pulses want 1 at %0d", short_lines, fe_cyc.size(), rise_cyc + 1);
    end
    vectors++;
    if (fd_cyc.size() != 0) begin
      miscompares++;
      $display("FAIL abort%0d frame_done: got %0d pulses want 0", short_lines, fd_cyc.size());
    end
    // the aborting vsync re-armed the block; the next frame must be complete
    fill_image(4);
    clear_mon();
    send_lines(0, SH, SW, -1, -1);
    build_exp();
    vectors++;
    if (o_dat.size() != OS * OS || fd_cyc.size() != 1 || fe_cyc.size() != 0) begin
      miscompares++;
      $display("FAIL abort%0d recovery: got %0d outputs %0d done %0d err", short_lines,
               o_dat.size(), fd_cyc.size(), fe_cyc.size());
    end
    vectors++;
    if (fs_cyc.size() != 1 || o_cyc.size() == 0 || fs_cyc[0] != o_cyc[0]) begin
      miscompares++;
      $display("FAIL abort%0d recovery_start: got %0d frame_start pulses", short_lines, fs_cyc.size());
    end
    n = (o_dat.size() < e_dat.size()) ? o_dat.size() : e_dat.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (o_dat[i] !== e_dat[i]) begin
        miscompares++;
        $display("FAIL abort%0d recovery_data[%0d]: got %h want %h", short_lines, i, o_dat[i], e_dat[i]);
      end
    end
  endtask

  task automatic test_enable();
    int n;
    fill_image(4);
    clear_mon();
    bus.en = 1'b0;
    vsync_start();
    send_lines(0, 10, SW, -1, -1);
    bus.en = 1'b1;
    send_lines(10, SH, SW, -1, -1);
    vectors++;
    if (o_dat.size() != 0 || fs_cyc.size() != 0 || fd_cyc.size() != 0 || fe_cyc.size() != 0) begin
      miscompares++;
      $display("FAIL enable_off: got %0d outputs %0d done %0d err want none",
               o_dat.size(), fd_cyc.size(), fe_cyc.size());
    end
    fill_image(4);
    clear_mon();
    vsync_start();
    send_lines(0, SH, SW, -1, -1);
    build_exp();
    vectors++;
    if (o_dat.size() != OS * OS || fd_cyc.size() != 1) begin
      miscompares++;
      $display("FAIL enable_next: got %0d outputs %0d done want %0d 1", o_dat.size(), fd_cyc.size(), OS * OS);
    end
    n = (o_dat.size() < e_dat.size()) ? o_dat.size() : e_dat.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (o_dat[i] !== e_dat[i] || o_cyc[i] != e_cyc[i]) begin
        miscompares++;
        $display("FAIL enable_next out[%0d]: got %h@%0d want %h@%0d", i, o_dat[i], o_cyc[i], e_dat[i], e_cyc[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int n, nexp;
    fill_image(4);
    clear_mon();
    vsync_start();
    send_lines(0, SH, SW, RY + 3 * SC - 1, RX + 3 * SC - 1 + 2);
    build_exp();
    nexp = 0;
    for (int i = 0; i < e_cyc.size(); i++) if (e_cyc[i] <= rst_cyc) nexp++;
    vectors++;
    if (pre_pv !== 1'b1 || pre_pd !== e_dat[nexp - 1]) begin
      miscompares++;
      $display("FAIL rst_mid_before: got valid %b data %h want 1 %h", pre_pv, pre_pd, e_dat[nexp - 1]);
    end
    vectors++;
    if (post_pv !== 1'b0 || post_pd !== 8'h00 || post_pulses !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_mid_after: got valid %b data %h pulses %b want 0", post_pv, post_pd, post_pulses);
    end
    vectors++;
    if (o_dat.size() != nexp || fd_cyc.size() != 0 || fe_cyc.size() != 0) begin
      miscompares++;
      $display("FAIL rst_mid_count: got %0d outputs %0d done %0d err want %0d 0 0",
               o_dat.size(), fd_cyc.size(), fe_cyc.size(), nexp);
    end
    n = (o_dat.size() < nexp) ? o_dat.size() : nexp;
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (o_dat[i] !== e_dat[i]) begin
        miscompares++;
        $display("FAIL rst_mid_data[%0d]: got %h want %h", i, o_dat[i], e_dat[i]);
      end
    end
    fill_image(2);
    clear_mon();
    vsync_start();
    send_lines(0, SH, SW, -1, -1);
    build_exp();
    vectors++;
    if (o_dat.size() != OS * OS || fd_cyc.size() != 1 || fs_cyc.size() != 1) begin
      miscompares++;
      $display("FAIL rst_mid_recovery: got %0d outputs %0d done %0d start", o_dat.size(), fd_cyc.size(), fs_cyc.size());
    end
    n = (o_dat.size() < e_dat.size()) ? o_dat.size() : e_dat.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (o_dat[i] !== e_dat[i]) begin
        miscompares++;
        $display("FAIL rst_mid_recovery_data[%0d]: got %h want %h", i, o_dat[i], e_dat[i]);
      end
    end
  endtask

  initial begin
    bus.en = 1'b1;
    bus.cam_href = 1'b0;
    bus.cam_vsync = 1'b0;
    bus.cam_data = 8'h00;
    test_reset();
    test_patterns();
    test_abort(1'b0);
    test_abort(1'b1);
    test_enable();
    test_reset_midframe();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
